// File: rtl/dbus_arbiter.sv
// Data-bus arbiter: shares one dbus port between the page-table walker (PTW)
// and the memory stage (MEM). PTW has priority; a starvation counter bounds MEM's wait.

package dbus_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  ptw_req,
    output dbus_resp_t ptw_resp,
    input  dbus_req_t  mem_req,
    output dbus_resp_t mem_resp,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_PTW = 2'd1,
        GRANT_MEM = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    dbus_req_t       req_q;
    logic [CNT_W-1:0] starve_cnt;

    logic starve_hit;
    logic pick_mem;
    logic pick_ptw;

    // MEM wins only when PTW is quiet or MEM has waited out STARVE_LIMIT PTW grants.
    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign pick_mem   = mem_req.valid && (!ptw_req.valid || starve_hit);
    assign pick_ptw   = !pick_mem && ptw_req.valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_mem) begin
                    next_state = GRANT_MEM;
                end else if (pick_ptw) begin
                    next_state = GRANT_PTW;
                end
            end
            GRANT_PTW,
            GRANT_MEM: begin
                if (dresp.data_ok) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The request is captured only at grant time so later requester edits cannot disturb the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
        end else if (state == IDLE) begin
            if (pick_mem) begin
                req_q <= mem_req;
            end else if (pick_ptw) begin
                req_q <= ptw_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_mem) begin
                starve_cnt <= '0;
            end else if (pick_ptw && mem_req.valid && !starve_hit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        dreq       = req_q;
        dreq.valid = (state != IDLE);
        busy       = (state != IDLE);
        owner      = (state == GRANT_MEM);
        ptw_resp   = '0;
        mem_resp   = '0;
        case (state)
            GRANT_PTW: ptw_resp = dresp;
            GRANT_MEM: mem_resp = dresp;
            default: begin
                ptw_resp = '0;
                mem_resp = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed self-checking bench for dbus_arbiter: grant priority, starvation,
// request latching, reset abandonment and addr_ok-only cycles.

module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic       clk;
    logic       reset;
    dbus_req_t  ptw_req;
    dbus_resp_t ptw_resp;
    dbus_req_t  mem_req;
    dbus_resp_t mem_resp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       busy;
    logic       owner;

    int compared;
    int mismatched;

    dbus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .ptw_req  (ptw_req),
        .ptw_resp (ptw_resp),
        .mem_req  (mem_req),
        .mem_resp (mem_resp),
        .dreq     (dreq),
        .dresp    (dresp),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow after a further settle delay.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [65:0] observed, input logic [65:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int ptw_n;
        int grants;
        logic exp_owner [6];
        int   exp_cnt   [6];

        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        ptw_req    = '0;
        mem_req    = '0;
        dresp      = '0;
        applyStimulus();
        applyStimulus();

        // Reset state
        #1;
        checkOutput("reset_dreq_valid", 66'(dreq.valid), 66'(0));
        checkOutput("reset_busy",       66'(busy),       66'(0));
        checkOutput("reset_owner",      66'(owner),      66'(0));
        checkOutput("reset_ptw_resp",   66'(ptw_resp),   66'(0));
        checkOutput("reset_mem_resp",   66'(mem_resp),   66'(0));
        reset = 1'b0;
        applyStimulus();

        // Single MEM transaction with PTW idle
        mem_req.valid = 1'b1;
        mem_req.addr  = 64'h0000_0000_8000_0010;
        mem_req.size  = MSIZE8;
        mem_req.strobe = 8'hFF;
        mem_req.data  = 64'h1111_2222_3333_4444;
        #1;
        checkOutput("t1_idle_dreq_valid", 66'(dreq.valid), 66'(0));
        applyStimulus();
        #1;
        checkOutput("t1_dreq_valid", 66'(dreq.valid), 66'(1));
        checkOutput("t1_dreq_addr",  66'(dreq.addr),  66'(64'h8000_0010));
        checkOutput("t1_dreq_size",  66'(dreq.size),  66'(MSIZE8));
        checkOutput("t1_dreq_data",  66'(dreq.data),  66'(64'h1111_2222_3333_4444));
        checkOutput("t1_owner",      66'(owner),      66'(1));
        checkOutput("t1_busy",       66'(busy),       66'(1));
        applyStimulus();
        applyStimulus();
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hDEAD_BEEF_0000_1234;
        #1;
        checkOutput("t1_mem_data_ok", 66'(mem_resp.data_ok), 66'(1));
        checkOutput("t1_mem_data",    66'(mem_resp.data),    66'(64'hDEAD_BEEF_0000_1234));
        checkOutput("t1_ptw_resp",    66'(ptw_resp),         66'(0));
        applyStimulus();
        mem_req = '0;
        dresp   = '0;
        #1;
        checkOutput("t1_after_dreq_valid", 66'(dreq.valid), 66'(0));
        checkOutput("t1_after_busy",       66'(busy),       66'(0));

        // Simultaneous request, counter at 0: PTW first, MEM after an IDLE cycle
        ptw_req.valid = 1'b1;
        ptw_req.addr  = 64'h0000_0000_0000_A000;
        ptw_req.size  = MSIZE8;
        mem_req.valid = 1'b1;
        mem_req.addr  = 64'h0000_0000_0000_B000;
        mem_req.size  = MSIZE4;
        applyStimulus();
        dresp.addr_ok = 1'b1;
        #1;
        checkOutput("t2_owner",        66'(owner),            66'(0));
        checkOutput("t2_dreq_addr",    66'(dreq.addr),        66'(64'hA000));
        checkOutput("t2_ptw_addr_ok",  66'(ptw_resp.addr_ok), 66'(1));
        checkOutput("t2_mem_resp_a",   66'(mem_resp),         66'(0));
        applyStimulus();
        dresp.addr_ok = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h0000_0000_0000_0ABC;
        #1;
        checkOutput("t2_ptw_data_ok",  66'(ptw_resp.data_ok), 66'(1));
        checkOutput("t2_ptw_data",     66'(ptw_resp.data),    66'(64'hABC));
        checkOutput("t2_mem_resp_b",   66'(mem_resp),         66'(0));
        checkOutput("t2_cnt_after_ptw", 66'(dut.starve_cnt),  66'(1));
        applyStimulus();
        ptw_req = '0;
        dresp   = '0;
        #1;
        checkOutput("t2_gap_busy", 66'(busy), 66'(0));
        applyStimulus();
        #1;
        checkOutput("t2_mem_owner",     66'(owner),          66'(1));
        checkOutput("t2_mem_dreq_addr", 66'(dreq.addr),      66'(64'hB000));
        checkOutput("t2_cnt_after_mem", 66'(dut.starve_cnt), 66'(0));
        dresp.data_ok = 1'b1;
        #1;
        checkOutput("t2_mem_data_ok", 66'(mem_resp.data_ok), 66'(1));
        applyStimulus();
        mem_req = '0;
        dresp   = '0;

        // Starvation: MEM waits through four PTW grants, then wins once
        exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_cnt   = '{1, 2, 3, 4, 0, 0};
        ptw_n = 0;
        mem_req.valid = 1'b1;
        mem_req.addr  = 64'h300;
        ptw_req.valid = 1'b1;
        ptw_req.addr  = 64'h1000;
        for (grants = 0; grants < 6; grants++) begin
            #1;
            checkOutput($sformatf("t3_idle_busy_%0d", grants), 66'(busy), 66'(0));
            applyStimulus();
            #1;
            checkOutput($sformatf("t3_owner_%0d", grants), 66'(owner), 66'(exp_owner[grants]));
            checkOutput($sformatf("t3_addr_%0d", grants), 66'(dreq.addr),
                        exp_owner[grants] ? 66'(64'h300) : 66'(64'h1000 + 64'(ptw_n) * 64'h8));
            checkOutput($sformatf("t3_cnt_%0d", grants), 66'(dut.starve_cnt), 66'(exp_cnt[grants]));
            dresp.data_ok = 1'b1;
            applyStimulus();
            dresp = '0;
            if (exp_owner[grants]) begin
                mem_req = '0;
            end else begin
                ptw_n++;
                ptw_req.addr = 64'h1000 + 64'(ptw_n) * 64'h8;
                if (ptw_n == 5) begin
                    ptw_req = '0;
                end
            end
        end

        // Requester edits its address mid-grant; the bus keeps the latched one
        mem_req.valid = 1'b1;
        mem_req.addr  = 64'h100;
        applyStimulus();
        mem_req.addr = 64'h200;
        #1;
        checkOutput("t4_addr_grant", 66'(dreq.addr), 66'(64'h100));
        applyStimulus();
        #1;
        checkOutput("t4_addr_mid", 66'(dreq.addr), 66'(64'h100));
        dresp.data_ok = 1'b1;
        #1;
        checkOutput("t4_addr_dok", 66'(dreq.addr), 66'(64'h100));
        applyStimulus();
        mem_req = '0;
        dresp   = '0;

        // Reset two cycles into a PTW transaction abandons it
        ptw_req.valid = 1'b1;
        ptw_req.addr  = 64'h2000;
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("t5_busy_before", 66'(busy), 66'(1));
        reset = 1'b1;
        applyStimulus();
        reset   = 1'b0;
        ptw_req = '0;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h5555;
        #1;
        checkOutput("t5_dreq_valid",   66'(dreq.valid),       66'(0));
        checkOutput("t5_busy",         66'(busy),             66'(0));
        checkOutput("t5_ptw_data_ok",  66'(ptw_resp.data_ok), 66'(0));
        checkOutput("t5_mem_resp",     66'(mem_resp),         66'(0));
        applyStimulus();
        dresp = '0;

        // addr_ok alone for four cycles keeps the grant
        mem_req.valid = 1'b1;
        mem_req.addr  = 64'h400;
        applyStimulus();
        for (int i = 0; i < 4; i++) begin
            dresp.addr_ok = 1'b1;
            #1;
            checkOutput($sformatf("t6_valid_%0d", i),   66'(dreq.valid),       66'(1));
            checkOutput($sformatf("t6_addr_%0d", i),    66'(dreq.addr),        66'(64'h400));
            checkOutput($sformatf("t6_busy_%0d", i),    66'(busy),             66'(1));
            checkOutput($sformatf("t6_addr_ok_%0d", i), 66'(mem_resp.addr_ok), 66'(1));
            checkOutput($sformatf("t6_data_ok_%0d", i), 66'(mem_resp.data_ok), 66'(0));
            applyStimulus();
        end
        dresp.addr_ok = 1'b0;
        dresp.data_ok = 1'b1;
        applyStimulus();
        mem_req = '0;
        dresp   = '0;

        // Stray responses while idle are not forwarded
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hFFFF;
        #1;
        checkOutput("t7_idle_ptw_resp", 66'(ptw_resp), 66'(0));
        checkOutput("t7_idle_mem_resp", 66'(mem_resp), 66'(0));
        applyStimulus();
        dresp = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
